seg7_scan_mux: RTL and testbench



---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_slot_timer.sv | 43 ++++
 rtl/seg7_scan_mux.sv | 140 ++++++++++++++
 tb/tb_seg7_scan_mux.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scanner.
package seg7_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [3:0] DIG_OFF    = 4'hF;

  typedef logic [7:0] seg_pat_t;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // One-cold (active-low) digit select for the given slot.
  function automatic logic [3:0] slot_sel(input logic [1:0] slot);
    slot_sel = ~(4'b0001 << slot);
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot timing for the scanner: a cycle counter that wraps every SLOT_CYCLES
// clocks and a 2-bit slot index that advances on each wrap.
module seg7_slot_timer #(
  parameter int SLOT_CYCLES  = 27_000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] slot,
  output logic       in_blank,
  output logic       blank_last,
  output logic       slot_wrap,
  output logic       frame_wrap
);

  localparam int            CW             = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT       = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_CNT      = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] BLANK_LAST_CNT = CW'(BLANK_CYCLES - 1);

  logic [CW-1:0] cnt;

  // blank_last flags the final blank cycle so the FSM can enter DRIVE in
  // step with the counter leaving the blank window.
  assign slot_wrap  = (cnt == LAST_CNT);
  assign in_blank   = (cnt < BLANK_CNT);
  assign blank_last = (cnt == BLANK_LAST_CNT);
  assign frame_wrap = slot_wrap && (slot == 2'd3);

  // Cycle counter and slot index; slot 3 wraps back to slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      slot <= 2'd0;
    end else if (slot_wrap) begin
      cnt  <= '0;
      slot <= slot + 2'd1;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 4-digit 7-segment scanner. Frames are double-buffered
// (shadow -> active) and only swap at the slot 3 -> slot 0 boundary; every
// slot starts with a blanking window to suppress ghosting.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int CLK_HZ       = 27_000_000,
  parameter int SCAN_HZ      = 1_000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] frame_in,
  input  logic [3:0]  digit_en,
  input  logic        load,
  output logic [7:0]  seg,
  output logic [3:0]  dig,
  output logic        frame_start,
  output logic        pending
);

  localparam int SLOT_CYCLES = CLK_HZ / SCAN_HZ;

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= SLOT_CYCLES) begin : g_bad_blank
    $error("seg7_scan_mux: BLANK_CYCLES must be in 1..CLK_HZ/SCAN_HZ-1");
  end

  logic [1:0]  slot;
  logic        in_blank;
  logic        blank_last;
  logic        slot_wrap;
  logic        frame_wrap;

  scan_state_t state;
  scan_state_t state_next;

  seg_pat_t    in_pat [NUM_DIGITS];
  seg_pat_t    shadow [NUM_DIGITS];
  seg_pat_t    active [NUM_DIGITS];
  logic [3:0]  shadow_en;
  logic [3:0]  active_en;

  logic [7:0]  seg_next;
  logic [3:0]  dig_next;

  seg7_slot_timer #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .slot       (slot),
    .in_blank   (in_blank),
    .blank_last (blank_last),
    .slot_wrap  (slot_wrap),
    .frame_wrap (frame_wrap)
  );

  // Split the incoming frame word into per-digit patterns (digit k on [8k+7:8k]).
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      in_pat[k] = frame_in[8*k +: 8];
    end
  end

  // Shadow/active double buffer; a load on the promotion cycle bypasses to active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
      shadow_en <= '0;
      active_en <= '0;
      pending   <= 1'b0;
    end else begin
      if (frame_wrap) begin
        if (load) begin
          active    <= in_pat;
          active_en <= digit_en;
        end else if (pending) begin
          active    <= shadow;
          active_en <= shadow_en;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
      if (load) begin
        shadow    <= in_pat;
        shadow_en <= digit_en;
      end
    end
  end

  // FSM state register, kept in step with the slot counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK;
    end else begin
      state <= state_next;
    end
  end

  // Next state: BLANK ends with the last blank cycle, DRIVE ends on slot wrap.
  // Leaving BLANK when the counter is already past the window keeps the FSM
  // from lingering if it were ever out of step.
  always_comb begin
    state_next = state;
    unique case (state)
      BLANK:   if (blank_last || !in_blank) state_next = DRIVE;
      DRIVE:   if (slot_wrap)               state_next = BLANK;
      default: state_next = BLANK;
    endcase
  end

  // Output decode: disabled digits still consume their slot, so duty stays 1/4.
  always_comb begin
    seg_next = SEG_OFF;
    dig_next = DIG_OFF;
    if (state == DRIVE && active_en[slot]) begin
      seg_next = ~active[slot];
      dig_next = slot_sel(slot);
    end
  end

  // Registered pad drive and frame marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg         <= SEG_OFF;
      dig         <= DIG_OFF;
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_next;
      dig         <= dig_next;
      frame_start <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: directed scenarios plus random loads, checked
// every cycle against a frame-position model of the display.
module tb_seg7_scan_mux;

  localparam int SLOT  = 10;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] frame_in = '0;
  logic [3:0]  digit_en = '0;
  logic        load = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame_start;
  logic        pending;

  seg7_scan_mux #(
    .CLK_HZ       (1000),
    .SCAN_HZ      (100),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_in    (frame_in),
    .digit_en    (digit_en),
    .load        (load),
    .seg         (seg),
    .dig         (dig),
    .frame_start (frame_start),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: displayed frame, buffered frame, and edges since reset release.
  logic [31:0] m_active;
  logic [31:0] m_shadow;
  logic [3:0]  m_en;
  logic [3:0]  m_shadow_en;
  logic        m_pending;
  int          e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"}, {24'd0, seg}, 32'hFF);
    check({tag, "_dig"}, {28'd0, dig}, 32'hF);
    check({tag, "_fs"},  {31'd0, frame_start}, 32'd0);
    check({tag, "_pend"}, {31'd0, pending}, 32'd0);
  endtask

  task automatic model_reset();
    m_active    = '0;
    m_shadow    = '0;
    m_en        = '0;
    m_shadow_en = '0;
    m_pending   = 1'b0;
    e           = 0;
  endtask

  // One clock: drive inputs, predict outputs from the frame position, check.
  task automatic tick(input logic ld, input logic [31:0] fr, input logic [3:0] en);
    int pos, s, c;
    logic [7:0] x_seg;
    logic [3:0] x_dig;
    logic       x_fs;
    load     = ld;
    frame_in = fr;
    digit_en = en;
    @(posedge clk);
    pos = e % FRAME;
    s   = pos / SLOT;
    c   = pos % SLOT;
    if (c < BLANK || !m_en[s]) begin
      x_seg = 8'hFF;
      x_dig = 4'hF;
    end else begin
      x_dig = ~(4'b0001 << s);
      x_seg = ~m_active[8*s +: 8];
    end
    x_fs = (pos == FRAME - 1);
    if (pos == FRAME - 1) begin
      if (ld) begin
        m_active = fr;
        m_en     = en;
      end else if (m_pending) begin
        m_active = m_shadow;
        m_en     = m_shadow_en;
      end
      m_pending = 1'b0;
    end else if (ld) begin
      m_pending = 1'b1;
    end
    if (ld) begin
      m_shadow    = fr;
      m_shadow_en = en;
    end
    e++;
    #1;
    load = 1'b0;
    check("seg", {24'd0, seg}, {24'd0, x_seg});
    check("dig", {28'd0, dig}, {28'd0, x_dig});
    check("frame_start", {31'd0, frame_start}, {31'd0, x_fs});
    check("pending", {31'd0, pending}, {31'd0, m_pending});
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, $urandom, 4'($urandom));
  endtask

  // Idle until the next edge lands on frame position p (bounded to one frame).
  task automatic run_to(input int p);
    for (int i = 0; i < FRAME && (e % FRAME) != p; i++) begin
      tick(1'b0, $urandom, 4'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Asynchronous reset assertion, then hold for 3 clocks.
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    repeat (3) begin
      @(posedge clk);
      #1 check_reset_outputs("rst_hold");
    end
    rst = 1'b0;
    model_reset();

    // Basic scan: full frame, all digits enabled, loaded at position 0.
    tick(1'b1, 32'h3F06_5B4F, 4'hF);
    idle(2 * FRAME + 5);

    // Disabled digits 1 and 3.
    run_to(5);
    tick(1'b1, 32'h6D7D_0777, 4'b0101);
    idle(2 * FRAME + 3);

    // Atomic update: A in slot 1, B in slot 2; only B should appear.
    run_to(3);
    tick(1'b1, 32'hFFFF_FFFF, 4'hF);
    run_to(13);
    tick(1'b1, 32'h1122_3344, 4'hF);
    run_to(24);
    tick(1'b1, 32'h5566_7788, 4'hF);
    idle(FRAME + 10);

    // Collision: load on the exact promotion cycle.
    run_to(FRAME - 1);
    tick(1'b1, 32'h99AA_BBCC, 4'hF);
    idle(FRAME + 5);

    // Random loads at random positions.
    repeat (600) tick(($urandom_range(0, 9) == 0), $urandom, 4'($urandom));

    // Mid-scan reset during slot 2 DRIVE with a frame pending.
    run_to(FRAME - 1);
    tick(1'b1, 32'h1234_5678, 4'hF);
    run_to(15);
    tick(1'b1, 32'hAABB_CCDD, 4'hF);
    run_to(25);
    tick(1'b0, $urandom, 4'($urandom));
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    repeat (2) begin
      @(posedge clk);
      #1 check_reset_outputs("rst_mid_hold");
    end
    rst = 1'b0;
    model_reset();
    idle(2 * FRAME + 5);

    // Recovery after reset.
    tick(1'b1, 32'h0F1E_2D3C, 4'hB);
    idle(2 * FRAME + 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
